// File: rtl/arm_main_fsm_if.sv
// Control bundle between the ARM main FSM and the multicycle datapath.
// The FSM is the slave: it consumes instruction fields and drives selects/enables.
interface arm_main_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic [3:0] state;

  modport master (
    output Op, Funct,
    input  IRWrite, NextPC, RegW, MemW, Branch, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUOp, state
  );

  modport slave (
    input  Op, Funct,
    output IRWrite, NextPC, RegW, MemW, Branch, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUOp, state
  );
endinterface

// File: rtl/arm_main_fsm.sv
// Multicycle ARM main controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback and emitting ungated enables plus datapath selects.
module arm_main_fsm (
  input  logic          clk,
  input  logic          rst_n,
  arm_main_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t state_q, state_d;

  // Only I and S/L bits of Funct steer the sequence; the rest go to the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^bus.Funct[4:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: state_d = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.ALUOp     = 1'b0;
    case (state_q)
      FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.NextPC    = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      MEMADR: bus.ALUSrcB = 2'b01;
      MEMRD:  bus.AdrSrc  = 1'b1;
      MEMWB: begin
        bus.RegW      = 1'b1;
        bus.ResultSrc = 2'b01;
      end
      MEMWR: begin
        bus.MemW   = 1'b1;
        bus.AdrSrc = 1'b1;
      end
      EXECR: bus.ALUOp = 1'b1;
      EXECI: begin
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 1'b1;
      end
      ALUWB: bus.RegW = 1'b1;
      BRANCH: begin
        bus.Branch    = 1'b1;
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
      end
      default: ;
    endcase
    // Reset squashes every strobe combinationally so nothing fires before the first edge.
    if (!rst_n) begin
      bus.IRWrite   = 1'b0;
      bus.NextPC    = 1'b0;
      bus.RegW      = 1'b0;
      bus.MemW      = 1'b0;
      bus.Branch    = 1'b0;
      bus.AdrSrc    = 1'b0;
      bus.ALUSrcA   = 1'b0;
      bus.ALUSrcB   = 2'b00;
      bus.ResultSrc = 2'b00;
      bus.ALUOp     = 1'b0;
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_arm_main_fsm.sv
// Randomized self-checking bench for arm_main_fsm against an instruction-level
// model: expected state walk per instruction class plus per-state output table.
module tb_arm_main_fsm;

  logic clk;
  logic rst_n;
  arm_main_fsm_if bus();

  arm_main_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int exp_seq[$];

  // {IRWrite,NextPC,RegW,MemW,Branch,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp}
  function automatic logic [11:0] act_out();
    return {bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.AdrSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUOp};
  endfunction

  function automatic logic [11:0] exp_out(input int s);
    case (s)
      0: return 12'b1_1_0_0_0_0_1_10_10_0;
      1: return 12'b0_0_0_0_0_0_1_10_10_0;
      2: return 12'b0_0_0_0_0_0_0_01_00_0;
      3: return 12'b0_0_0_0_0_1_0_00_00_0;
      4: return 12'b0_0_1_0_0_0_0_00_01_0;
      5: return 12'b0_0_0_1_0_1_0_00_00_0;
      6: return 12'b0_0_0_0_0_0_0_00_00_1;
      7: return 12'b0_0_0_0_0_0_0_01_00_1;
      8: return 12'b0_0_1_0_0_0_0_00_00_0;
      9: return 12'b0_0_0_0_1_0_0_01_10_0;
      default: return 12'b0;
    endcase
  endfunction

  // Instruction-level model: state walk and cycle count by instruction class.
  task automatic make_seq(input logic [1:0] op, input logic [5:0] funct);
    exp_seq = {0, 1};
    case (op)
      2'b00: begin exp_seq.push_back(funct[5] ? 7 : 6); exp_seq.push_back(8); end
      2'b01: begin
        exp_seq.push_back(2);
        if (funct[0]) begin exp_seq.push_back(3); exp_seq.push_back(4); end
        else exp_seq.push_back(5);
      end
      2'b10: exp_seq.push_back(9);
      default: ;
    endcase
  endtask

  function automatic int exp_latency(input logic [1:0] op, input logic [5:0] funct);
    case (op)
      2'b00:   return 4;
      2'b01:   return funct[0] ? 5 : 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  // Called just after a rising edge with the FSM in FETCH. Inputs carry the
  // real instruction only in DECODE/MEMADR; garbage elsewhere must be ignored.
  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] funct);
    int ncyc;
    make_seq(op, funct);
    ncyc = exp_seq.size();
    checks++;
    if (ncyc !== exp_latency(op, funct)) begin
      errors++;
      $display("FAIL %s latency model=%0d required=%0d", name, ncyc, exp_latency(op, funct));
    end
    foreach (exp_seq[i]) begin
      checks++;
      if (bus.state !== exp_seq[i][3:0]) begin
        errors++;
        $display("FAIL %s state[%0d] got=%0d exp=%0d", name, i, bus.state, exp_seq[i]);
      end
      checks++;
      if (act_out() !== exp_out(exp_seq[i])) begin
        errors++;
        $display("FAIL %s outs[%0d] st=%0d got=%b exp=%b", name, i, exp_seq[i],
                 act_out(), exp_out(exp_seq[i]));
      end
      if (exp_seq[i] == 1 || exp_seq[i] == 2) begin
        bus.Op = op; bus.Funct = funct;
      end else begin
        bus.Op = 2'($urandom); bus.Funct = 6'($urandom);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.state !== 4'd0) begin
      errors++;
      $display("FAIL %s end_state got=%0d exp=0", name, bus.state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      bus.Op = 2'($urandom); bus.Funct = 6'($urandom);
      @(posedge clk); #1;
    end
    checks++;
    if (bus.state !== 4'd0) begin
      errors++; $display("FAIL reset_state got=%0d exp=0", bus.state);
    end
    checks++;
    if (act_out() !== 12'b0) begin
      errors++; $display("FAIL reset_outs got=%b exp=%b", act_out(), 12'b0);
    end
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if (act_out() !== exp_out(0)) begin
      errors++; $display("FAIL release_fetch got=%b exp=%b", act_out(), exp_out(0));
    end
    @(posedge clk); #1;   // this edge executes FETCH
    checks++;
    if (bus.state !== 4'd1) begin
      errors++; $display("FAIL first_edge got=%0d exp=1", bus.state);
    end
    repeat (3) @(posedge clk);  // DECODE -> FETCH path needs Op=11
    rst_n = 1'b0; #2 rst_n = 1'b1;
    @(posedge clk); #1;
    // back in DECODE after one edge from FETCH; finish with undefined op
    bus.Op = 2'b11;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_instr("add_reg", 2'b00, 6'b001000);
    run_instr("sub_imm", 2'b00, 6'b100101);
    run_instr("ldr",     2'b01, 6'b011001);
    run_instr("str",     2'b01, 6'b011000);
    run_instr("branch",  2'b10, 6'b000000);
    run_instr("undef",   2'b11, 6'b111111);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++)
      run_instr("rand", 2'($urandom), 6'($urandom));
  endtask

  task automatic test_reset_mid_memwr();
    bus.Op = 2'($urandom); @(posedge clk); #1;          // FETCH -> DECODE
    bus.Op = 2'b01; bus.Funct = 6'b011000; @(posedge clk); #1;  // -> MEMADR
    @(posedge clk); #1;                                 // -> MEMWR
    checks++;
    if (bus.state !== 4'd5 || bus.MemW !== 1'b1) begin
      errors++; $display("FAIL memwr_enter state=%0d MemW=%b exp 5/1", bus.state, bus.MemW);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.MemW !== 1'b0 || bus.state !== 4'd0) begin
      errors++; $display("FAIL memwr_async MemW=%b state=%0d exp 0/0", bus.MemW, bus.state);
    end
    checks++;
    if (act_out() !== 12'b0) begin
      errors++; $display("FAIL memwr_async_outs got=%b exp=0", act_out());
    end
    #3 rst_n = 1'b1;
    #1;
    run_instr("after_reset_ldr", 2'b01, 6'b000001);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.Op = 2'b00;
    bus.Funct = 6'b0;
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_memwr();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
